// File: rtl/controle_ula.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : controle_ula
// Purpose  : Sequencer for the 4-bit ULA datapath. Accepts one command per
//            start/done handshake and drives the regX/regY control codes and
//            the ULA operation select. It also runs a multi-cycle multiply by
//            repeated addition, using an internal down-counter.
// Revision : 1.0 - initial release
// ============================================================================
module controle_ula #(
  parameter int LARGURA_CNT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [2:0]             opcode,
  input  logic [LARGURA_CNT-1:0] vezes,
  output logic [1:0]             controleX,
  output logic [1:0]             controleY,
  output logic [1:0]             selULA,
  output logic                   ocupado,
  output logic                   pronto
);

  // Sequencer states
  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] LIMPA   = 2'd1;
  localparam logic [1:0] EXECUTA = 2'd2;
  localparam logic [1:0] FIM     = 2'd3;

  // Register control codes
  localparam logic [1:0] C_CLEAR = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_HOLD  = 2'd2;
  localparam logic [1:0] C_SHIFT = 2'd3;

  // ULA operation selects
  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_AND = 2'b10;
  localparam logic [1:0] ULA_OR  = 2'b11;

  // Opcodes
  localparam logic [2:0] OP_LIMPA_Y   = 3'b000;
  localparam logic [2:0] OP_CARREGA_X = 3'b001;
  localparam logic [2:0] OP_SOMA      = 3'b010;
  localparam logic [2:0] OP_SUB       = 3'b011;
  localparam logic [2:0] OP_E         = 3'b100;
  localparam logic [2:0] OP_OU        = 3'b101;
  localparam logic [2:0] OP_DESLOCA   = 3'b110;
  localparam logic [2:0] OP_MULT      = 3'b111;

  localparam logic [LARGURA_CNT-1:0] CNT_ZERO = '0;
  localparam logic [LARGURA_CNT-1:0] CNT_UM   = LARGURA_CNT'(1);

  logic [1:0]             r_estado;
  logic [2:0]             r_opcode;
  logic [LARGURA_CNT-1:0] r_vezes;
  logic [LARGURA_CNT-1:0] r_cnt;
  logic [1:0]             w_prox;

  // Next-state decode; MULT leaves EXECUTA when the last LOAD is issued
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (inicio) begin
          w_prox = (opcode == OP_MULT) ? LIMPA : EXECUTA;
        end
      end
      LIMPA: begin
        w_prox = (r_vezes == CNT_ZERO) ? FIM : EXECUTA;
      end
      EXECUTA: begin
        if (r_opcode != OP_MULT) begin
          w_prox = FIM;
        end else if (r_cnt <= CNT_UM) begin
          // Also exits on zero so the loop can never run away
          w_prox = FIM;
        end
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
  end

  // State, command latch and repetition counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_opcode <= 3'b000;
      r_vezes  <= CNT_ZERO;
      r_cnt    <= CNT_ZERO;
    end else begin
      r_estado <= w_prox;
      if ((r_estado == OCIOSO) && inicio) begin
        r_opcode <= opcode;
        r_vezes  <= vezes;
      end
      if (r_estado == LIMPA) begin
        r_cnt <= r_vezes;
      end else if ((r_estado == EXECUTA) && (r_opcode == OP_MULT) &&
                   (r_cnt != CNT_ZERO)) begin
        r_cnt <= r_cnt - CNT_UM;
      end
    end
  end

  // Moore output decode from state and latched opcode only
  always_comb begin
    controleX = C_HOLD;
    controleY = C_HOLD;
    selULA    = ULA_ADD;
    ocupado   = 1'b0;
    pronto    = 1'b0;
    case (r_estado)
      LIMPA: begin
        ocupado   = 1'b1;
        controleY = C_CLEAR;
      end
      EXECUTA: begin
        ocupado = 1'b1;
        case (r_opcode)
          OP_LIMPA_Y:   controleY = C_CLEAR;
          OP_CARREGA_X: controleX = C_LOAD;
          OP_SOMA: begin
            controleY = C_LOAD;
            selULA    = ULA_ADD;
          end
          OP_SUB: begin
            controleY = C_LOAD;
            selULA    = ULA_SUB;
          end
          OP_E: begin
            controleY = C_LOAD;
            selULA    = ULA_AND;
          end
          OP_OU: begin
            controleY = C_LOAD;
            selULA    = ULA_OR;
          end
          OP_DESLOCA:   controleY = C_SHIFT;
          default: begin
            // MULT: accumulate X into Y once per cycle
            controleY = C_LOAD;
            selULA    = ULA_ADD;
          end
        endcase
      end
      FIM: begin
        pronto = 1'b1;
      end
      default: begin
        ocupado = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_ula.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_controle_ula
// Purpose  : Self-checking bench for controle_ula with a small regX/regY/ULA
//            stand-in and a command-level reference of the expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_ula;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicio = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [3:0] vezes = 4'd0;
  logic [1:0] controleX, controleY, selULA;
  logic       ocupado, pronto;

  int errors = 0;
  int checks = 0;

  // Datapath stand-in
  logic [3:0] din = 4'd0;
  logic [3:0] mX = 4'd0;
  logic [3:0] mY = 4'd0;

  // Expected per-cycle outputs packed as {cx, cy, sel, ocupado, pronto}
  logic [7:0] exp_o [0:31];
  int         exp_len;
  logic [7:0] w_obs;

  assign w_obs = {controleX, controleY, selULA, ocupado, pronto};

  controle_ula #(.LARGURA_CNT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .inicio    (inicio),
    .opcode    (opcode),
    .vezes     (vezes),
    .controleX (controleX),
    .controleY (controleY),
    .selULA    (selULA),
    .ocupado   (ocupado),
    .pronto    (pronto)
  );

  always #5 clock = ~clock;

  // regX / regY / ULA behaviour driven by the sequencer outputs
  always @(posedge clock) begin
    case (controleX)
      2'd0: mX <= 4'd0;
      2'd1: mX <= din;
      2'd3: mX <= {mX[2:0], 1'b0};
      default: mX <= mX;
    endcase
    case (controleY)
      2'd0: mY <= 4'd0;
      2'd1: begin
        case (selULA)
          2'b00: mY <= mY + mX;
          2'b01: mY <= mY - mX;
          2'b10: mY <= mY & mX;
          default: mY <= mY | mX;
        endcase
      end
      2'd3: mY <= {mY[2:0], 1'b0};
      default: mY <= mY;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pk(input int cx, input int cy, input int sel,
                                    input int oc, input int pr);
    logic [1:0] a, b, c;
    a = cx[1:0];
    b = cy[1:0];
    c = sel[1:0];
    return {a, b, c, oc[0], pr[0]};
  endfunction

  // Command-level reference: list of outputs from the cycle after inicio
  // is accepted up to and including the pronto cycle
  task automatic build_expect(input logic [2:0] op, input int n);
    exp_len = 0;
    if (op == 3'b111) begin
      exp_o[exp_len] = pk(2, 0, 0, 1, 0); exp_len++;
      for (int i = 0; i < n; i++) begin
        exp_o[exp_len] = pk(2, 1, 0, 1, 0); exp_len++;
      end
    end else begin
      case (op)
        3'd0: exp_o[0] = pk(2, 0, 0, 1, 0);
        3'd1: exp_o[0] = pk(1, 2, 0, 1, 0);
        3'd2: exp_o[0] = pk(2, 1, 0, 1, 0);
        3'd3: exp_o[0] = pk(2, 1, 1, 1, 0);
        3'd4: exp_o[0] = pk(2, 1, 2, 1, 0);
        3'd5: exp_o[0] = pk(2, 1, 3, 1, 0);
        default: exp_o[0] = pk(2, 3, 0, 1, 0);
      endcase
      exp_len = 1;
    end
    exp_o[exp_len] = pk(2, 2, 0, 0, 1); exp_len++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one command for a single sampling edge, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic [3:0] n);
    inicio = 1'b1;
    opcode = op;
    vezes  = n;
    tick();
    inicio = 1'b0;
    opcode = 3'($urandom);
    vezes  = 4'($urandom);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    inicio = 1'b1;
    opcode = 3'b010;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (w_obs !== pk(2, 2, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h required %h", i, w_obs, pk(2, 2, 0, 0, 0));
      end
    end
    inicio = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (w_obs !== pk(2, 2, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %h required %h", i, w_obs, pk(2, 2, 0, 0, 0));
      end
    end
  endtask

  task automatic test_single_ops();
    logic [2:0] op;
    for (int t = 0; t < 14; t++) begin
      op = (t < 7) ? 3'(t) : 3'($urandom_range(0, 6));
      issue(op, 4'($urandom));
      build_expect(op, 0);
      for (int i = 0; i < exp_len; i++) begin
        checks++;
        if (w_obs !== exp_o[i]) begin
          errors++;
          $display("FAIL single_op op=%0d cycle %0d: got %h required %h", op, i, w_obs, exp_o[i]);
        end
        tick();
      end
      checks++;
      if (w_obs !== pk(2, 2, 0, 0, 0)) begin
        errors++;
        $display("FAIL single_op_idle op=%0d: got %h required %h", op, w_obs, pk(2, 2, 0, 0, 0));
      end
    end
  endtask

  task automatic test_mult();
    logic [3:0] xv, nv, want;
    for (int t = 0; t < 9; t++) begin
      case (t)
        0: begin xv = 4'd5; nv = 4'd3; end
        1: begin xv = 4'd5; nv = 4'd5; end
        2: begin xv = 4'd5; nv = 4'd0; end
        3: begin xv = 4'd7; nv = 4'd1; end
        default: begin xv = 4'($urandom); nv = 4'($urandom); end
      endcase
      // Load X through the sequencer
      din = xv;
      issue(3'b001, 4'd0);
      tick();
      tick();
      issue(3'b111, nv);
      build_expect(3'b111, int'(nv));
      for (int i = 0; i < exp_len; i++) begin
        checks++;
        if (w_obs !== exp_o[i]) begin
          errors++;
          $display("FAIL mult n=%0d cycle %0d: got %h required %h", nv, i, w_obs, exp_o[i]);
        end
        tick();
      end
      want = 4'((int'(xv) * int'(nv)) % 16);
      checks++;
      if (mY !== want) begin
        errors++;
        $display("FAIL mult_result x=%0d n=%0d: got Y=%0d required Y=%0d", xv, nv, mY, want);
      end
      checks++;
      if (w_obs !== pk(2, 2, 0, 0, 0)) begin
        errors++;
        $display("FAIL mult_idle n=%0d: got %h required %h", nv, w_obs, pk(2, 2, 0, 0, 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [0:5];
    seq[0] = pk(2, 1, 0, 1, 0);  // SOMA
    seq[1] = pk(2, 2, 0, 0, 1);  // pronto
    seq[2] = pk(2, 2, 0, 0, 0);  // idle, second inicio sampled here
    seq[3] = pk(2, 3, 0, 1, 0);  // DESLOCA
    seq[4] = pk(2, 2, 0, 0, 1);  // pronto
    seq[5] = pk(2, 2, 0, 0, 0);  // idle
    inicio = 1'b1;
    opcode = 3'b010;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) opcode = 3'b110;
      if (i == 3) inicio = 1'b0;
      checks++;
      if (w_obs !== seq[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h required %h", i, w_obs, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mult();
    issue(3'b111, 4'd4);
    checks++;
    if (w_obs !== pk(2, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL abort_clear: got %h required %h", w_obs, pk(2, 0, 0, 1, 0));
    end
    tick();
    tick();
    checks++;
    if (w_obs !== pk(2, 1, 0, 1, 0)) begin
      errors++;
      $display("FAIL abort_load2: got %h required %h", w_obs, pk(2, 1, 0, 1, 0));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (w_obs !== pk(2, 2, 0, 0, 0)) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: got %h required %h", i, w_obs, pk(2, 2, 0, 0, 0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_mult();
    test_back_to_back();
    test_reset_mid_mult();
    test_mult();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
